// File: rtl/plic_lite.sv
// Minimal PLIC: level gateways, priority/threshold arbitration,
// claim/complete handshake and a registered MEIP output.
module plic_lite #(
    parameter int NSRC   = 8,
    parameter int PRIO_W = 3
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [NSRC-1:0]   irq_src,
    input  logic              cfg_we,
    input  logic              cfg_re,
    input  logic [5:0]        cfg_addr,
    input  logic [31:0]       cfg_wdata,
    output logic [31:0]       cfg_rdata,
    input  logic              claim_req,
    output logic [4:0]        claim_id,
    input  logic              complete_req,
    input  logic [4:0]        complete_id,
    output logic              meip
);

    logic [PRIO_W-1:0] r_prio [NSRC];
    logic [NSRC-1:0]   r_en;
    logic [PRIO_W-1:0] r_thr;
    logic [NSRC-1:0]   r_pend;
    logic [NSRC-1:0]   r_infl;

    logic [NSRC-1:0]   w_elig;
    logic [PRIO_W-1:0] w_best_prio;
    logic [4:0]        w_best_id;
    logic [NSRC-1:0]   w_clm_mask;
    logic [NSRC-1:0]   w_cmp_mask;
    logic [NSRC-1:0]   w_pend_nxt;
    logic [NSRC-1:0]   w_infl_nxt;
    logic [31:0]       w_rdata;

    // Strict '>' keeps the lowest ID on priority ties.
    always_comb begin
        w_best_prio = '0;
        w_best_id   = '0;
        for (int i = 0; i < NSRC; i++) begin
            w_elig[i] = r_pend[i] & r_en[i] & (r_prio[i] > r_thr);
            if (w_elig[i] && (r_prio[i] > w_best_prio)) begin
                w_best_prio = r_prio[i];
                w_best_id   = 5'(i + 1);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            w_clm_mask[i] = claim_req && (w_best_id == 5'(i + 1));
            w_cmp_mask[i] = complete_req && (complete_id == 5'(i + 1));
        end
    end

    // Claim is applied last so it wins over a same-cycle set or complete.
    assign w_infl_nxt = (r_infl & ~w_cmp_mask) | w_clm_mask;
    assign w_pend_nxt = (r_pend | (irq_src & ~r_infl)) & ~w_clm_mask;

    always_comb begin
        w_rdata = '0;
        if (cfg_addr == 6'h20) w_rdata = 32'({r_en, 1'b0});
        if (cfg_addr == 6'h21) w_rdata = 32'(r_thr);
        if (cfg_addr == 6'h22) w_rdata = 32'({r_pend, 1'b0});
        for (int i = 0; i < NSRC; i++) begin
            if (cfg_addr == 6'(i + 1)) w_rdata = 32'(r_prio[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < NSRC; i++) r_prio[i] <= '0;
            r_en      <= '0;
            r_thr     <= '0;
            r_pend    <= '0;
            r_infl    <= '0;
            meip      <= 1'b0;
            claim_id  <= '0;
            cfg_rdata <= '0;
        end else begin
            r_pend <= w_pend_nxt;
            r_infl <= w_infl_nxt;
            meip   <= (w_best_id != 5'd0);
            if (claim_req) claim_id <= w_best_id;
            if (cfg_re) cfg_rdata <= w_rdata;
            if (cfg_we) begin
                if (cfg_addr == 6'h20) r_en  <= cfg_wdata[NSRC:1];
                if (cfg_addr == 6'h21) r_thr <= cfg_wdata[PRIO_W-1:0];
                for (int i = 0; i < NSRC; i++) begin
                    if (cfg_addr == 6'(i + 1)) r_prio[i] <= cfg_wdata[PRIO_W-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_plic_lite.sv
// Directed bench for plic_lite: vector table for the main flows
// plus hand-written claim/complete/reset sequences.
module tb_plic_lite;

    logic        clk = 1'b0;
    logic        resetn;
    logic [7:0]  irq_src;
    logic        cfg_we, cfg_re;
    logic [5:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;
    logic        claim_req;
    logic [4:0]  claim_id;
    logic        complete_req;
    logic [4:0]  complete_id;
    logic        meip;

    int n_run  = 0;
    int n_fail = 0;

    plic_lite #(.NSRC(8), .PRIO_W(3)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .irq_src      (irq_src),
        .cfg_we       (cfg_we),
        .cfg_re       (cfg_re),
        .cfg_addr     (cfg_addr),
        .cfg_wdata    (cfg_wdata),
        .cfg_rdata    (cfg_rdata),
        .claim_req    (claim_req),
        .claim_id     (claim_id),
        .complete_req (complete_req),
        .complete_id  (complete_id),
        .meip         (meip)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  irq;
        logic        we;
        logic        re;
        logic [5:0]  addr;
        logic [31:0] wd;
        logic        clm;
        logic        cmp;
        logic [4:0]  cid;
        logic        e_meip;
        logic [4:0]  e_cid;
        logic        ck_rd;
        logic [31:0] e_rd;
    } vec_t;

    vec_t vt [$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic [7:0] irq, input logic we, input logic re,
                        input logic [5:0] addr, input logic [31:0] wd,
                        input logic clm, input logic cmp, input logic [4:0] cid);
        irq_src      = irq;
        cfg_we       = we;
        cfg_re       = re;
        cfg_addr     = addr;
        cfg_wdata    = wd;
        claim_req    = clm;
        complete_req = cmp;
        complete_id  = cid;
        @(posedge clk);
        #1;
    endtask

    task automatic addv(input logic [7:0] irq, input logic we, input logic re,
                        input logic [5:0] addr, input logic [31:0] wd,
                        input logic clm, input logic cmp, input logic [4:0] cid,
                        input logic em, input logic [4:0] ec,
                        input logic ckr, input logic [31:0] er);
        vec_t v;
        v = '{irq, we, re, addr, wd, clm, cmp, cid, em, ec, ckr, er};
        vt.push_back(v);
    endtask

    initial begin
        // single source, pulse, claim, complete
        addv(8'h00, 1, 0, 6'h03, 32'd2,     0, 0, 5'd0, 0, 5'd0, 0, 32'h0);
        addv(8'h00, 1, 0, 6'h20, 32'h08,    0, 0, 5'd0, 0, 5'd0, 0, 32'h0);
        addv(8'h00, 1, 0, 6'h21, 32'h0,     0, 0, 5'd0, 0, 5'd0, 0, 32'h0);
        addv(8'h04, 0, 0, 6'h00, 32'h0,     0, 0, 5'd0, 0, 5'd0, 0, 32'h0);
        addv(8'h00, 0, 1, 6'h22, 32'h0,     0, 0, 5'd0, 1, 5'd0, 1, 32'h08);
        addv(8'h00, 0, 0, 6'h00, 32'h0,     1, 0, 5'd0, 1, 5'd3, 0, 32'h0);
        addv(8'h00, 0, 1, 6'h22, 32'h0,     0, 0, 5'd0, 0, 5'd3, 1, 32'h0);
        addv(8'h00, 0, 0, 6'h00, 32'h0,     0, 1, 5'd3, 0, 5'd3, 0, 32'h0);
        // priority order and tie break
        addv(8'h00, 1, 0, 6'h02, 32'd5,     0, 0, 5'd0, 0, 5'd3, 0, 32'h0);
        addv(8'h00, 1, 0, 6'h05, 32'd5,     0, 0, 5'd0, 0, 5'd3, 0, 32'h0);
        addv(8'h00, 1, 0, 6'h06, 32'd7,     0, 0, 5'd0, 0, 5'd3, 0, 32'h0);
        addv(8'h00, 1, 0, 6'h20, 32'h1FE,   0, 0, 5'd0, 0, 5'd3, 0, 32'h0);
        addv(8'h32, 0, 0, 6'h00, 32'h0,     0, 0, 5'd0, 0, 5'd3, 0, 32'h0);
        addv(8'h32, 0, 0, 6'h00, 32'h0,     1, 0, 5'd0, 1, 5'd6, 0, 32'h0);
        addv(8'h32, 0, 0, 6'h00, 32'h0,     1, 0, 5'd0, 1, 5'd2, 0, 32'h0);
        addv(8'h32, 0, 0, 6'h00, 32'h0,     1, 0, 5'd0, 1, 5'd5, 0, 32'h0);
        addv(8'h32, 0, 0, 6'h00, 32'h0,     1, 0, 5'd0, 0, 5'd0, 0, 32'h0);
        addv(8'h00, 0, 0, 6'h00, 32'h0,     0, 1, 5'd6, 0, 5'd0, 0, 32'h0);
        addv(8'h00, 0, 0, 6'h00, 32'h0,     0, 1, 5'd2, 0, 5'd0, 0, 32'h0);
        addv(8'h00, 0, 0, 6'h00, 32'h0,     0, 1, 5'd5, 0, 5'd0, 0, 32'h0);
        // threshold boundary
        addv(8'h00, 1, 0, 6'h21, 32'd4,     0, 0, 5'd0, 0, 5'd0, 0, 32'h0);
        addv(8'h00, 1, 0, 6'h01, 32'd4,     0, 0, 5'd0, 0, 5'd0, 0, 32'h0);
        addv(8'h01, 0, 0, 6'h00, 32'h0,     0, 0, 5'd0, 0, 5'd0, 0, 32'h0);
        addv(8'h01, 0, 0, 6'h00, 32'h0,     0, 0, 5'd0, 0, 5'd0, 0, 32'h0);
        addv(8'h01, 1, 0, 6'h21, 32'd3,     0, 0, 5'd0, 0, 5'd0, 0, 32'h0);
        addv(8'h01, 0, 1, 6'h21, 32'h0,     0, 0, 5'd0, 1, 5'd0, 1, 32'd3);
        addv(8'h00, 0, 0, 6'h00, 32'h0,     1, 0, 5'd0, 1, 5'd1, 0, 32'h0);
        addv(8'h00, 0, 1, 6'h20, 32'h0,     0, 1, 5'd1, 0, 5'd1, 1, 32'h1FE);
        // register port corners
        addv(8'h00, 0, 1, 6'h06, 32'h0,     0, 0, 5'd0, 0, 5'd1, 1, 32'd7);
        addv(8'h00, 1, 1, 6'h30, 32'hFFFF,  0, 0, 5'd0, 0, 5'd1, 1, 32'h0);
        addv(8'h00, 1, 0, 6'h22, 32'hFF,    0, 0, 5'd0, 0, 5'd1, 0, 32'h0);
        addv(8'h00, 0, 1, 6'h22, 32'h0,     0, 0, 5'd0, 0, 5'd1, 1, 32'h0);
        addv(8'h00, 1, 1, 6'h06, 32'd1,     0, 0, 5'd0, 0, 5'd1, 1, 32'd7);
        addv(8'h00, 0, 1, 6'h06, 32'h0,     0, 0, 5'd0, 0, 5'd1, 1, 32'd1);

        resetn = 1'b0;
        step(8'h00, 0, 0, 6'h00, 32'h0, 0, 0, 5'd0);
        step(8'h00, 0, 0, 6'h00, 32'h0, 0, 0, 5'd0);
        chk("rst_meip", 32'(meip), 32'd0);
        chk("rst_cid", 32'(claim_id), 32'd0);
        chk("rst_rdata", cfg_rdata, 32'd0);
        resetn = 1'b1;

        foreach (vt[k]) begin
            step(vt[k].irq, vt[k].we, vt[k].re, vt[k].addr, vt[k].wd,
                 vt[k].clm, vt[k].cmp, vt[k].cid);
            chk($sformatf("v%0d_meip", k), 32'(meip), 32'(vt[k].e_meip));
            chk($sformatf("v%0d_cid", k), 32'(claim_id), 32'(vt[k].e_cid));
            if (vt[k].ck_rd)
                chk($sformatf("v%0d_rd", k), cfg_rdata, vt[k].e_rd);
        end

        // claim with line held, re-pend only after complete
        step(8'h00, 1, 0, 6'h21, 32'h0, 0, 0, 5'd0);
        step(8'h04, 0, 0, 6'h00, 32'h0, 0, 0, 5'd0);
        chk("a1_meip", 32'(meip), 32'd0);
        step(8'h04, 0, 0, 6'h00, 32'h0, 0, 0, 5'd0);
        chk("a2_meip", 32'(meip), 32'd1);
        step(8'h04, 0, 0, 6'h00, 32'h0, 1, 0, 5'd0);
        chk("a3_cid", 32'(claim_id), 32'd3);
        step(8'h04, 0, 1, 6'h22, 32'h0, 0, 0, 5'd0);
        chk("a4_pend", cfg_rdata, 32'h0);
        chk("a4_meip", 32'(meip), 32'd0);
        step(8'h04, 0, 0, 6'h00, 32'h0, 0, 0, 5'd0);
        chk("a5_meip", 32'(meip), 32'd0);
        step(8'h04, 0, 0, 6'h00, 32'h0, 0, 1, 5'd3);
        chk("a6_meip", 32'(meip), 32'd0);
        step(8'h04, 0, 0, 6'h00, 32'h0, 0, 0, 5'd0);
        chk("a7_meip", 32'(meip), 32'd0);
        step(8'h04, 0, 1, 6'h22, 32'h0, 0, 0, 5'd0);
        chk("a8_pend", cfg_rdata, 32'h08);
        chk("a8_meip", 32'(meip), 32'd1);

        // simultaneous claim and complete, out-of-range completes
        step(8'h04, 0, 0, 6'h00, 32'h0, 1, 0, 5'd0);
        chk("b1_cid", 32'(claim_id), 32'd3);
        step(8'h0C, 1, 0, 6'h04, 32'd3, 0, 0, 5'd0);
        chk("b2_meip", 32'(meip), 32'd0);
        step(8'h0C, 0, 0, 6'h00, 32'h0, 1, 1, 5'd3);
        chk("b3_cid", 32'(claim_id), 32'd4);
        chk("b3_meip", 32'(meip), 32'd1);
        step(8'h0C, 0, 1, 6'h22, 32'h0, 0, 1, 5'd9);
        chk("b4_pend", cfg_rdata, 32'h0);
        chk("b4_meip", 32'(meip), 32'd0);
        step(8'h0C, 0, 1, 6'h22, 32'h0, 0, 1, 5'd12);
        chk("b5_pend", cfg_rdata, 32'h08);
        chk("b5_meip", 32'(meip), 32'd1);
        step(8'h0C, 0, 0, 6'h00, 32'h0, 0, 1, 5'd0);
        step(8'h0C, 0, 0, 6'h00, 32'h0, 1, 0, 5'd0);
        chk("b7_cid", 32'(claim_id), 32'd3);
        step(8'h0C, 0, 1, 6'h22, 32'h0, 0, 0, 5'd0);
        chk("b8_pend", cfg_rdata, 32'h0);
        chk("b8_meip", 32'(meip), 32'd0);

        // reset with IDs 3 and 4 inflight
        step(8'h0D, 0, 0, 6'h00, 32'h0, 0, 0, 5'd0);
        step(8'h0D, 0, 0, 6'h00, 32'h0, 0, 0, 5'd0);
        chk("c2_meip", 32'(meip), 32'd1);
        resetn = 1'b0;
        step(8'h0D, 0, 1, 6'h20, 32'h0, 0, 0, 5'd0);
        chk("c3_meip", 32'(meip), 32'd0);
        chk("c3_cid", 32'(claim_id), 32'd0);
        chk("c3_rd", cfg_rdata, 32'h0);
        resetn = 1'b1;
        step(8'h00, 0, 1, 6'h01, 32'h0, 0, 0, 5'd0);
        chk("c4_prio1", cfg_rdata, 32'h0);
        step(8'h00, 0, 1, 6'h20, 32'h0, 0, 0, 5'd0);
        chk("c5_en", cfg_rdata, 32'h0);
        step(8'h00, 0, 1, 6'h21, 32'h0, 0, 0, 5'd0);
        chk("c6_thr", cfg_rdata, 32'h0);
        step(8'h00, 0, 1, 6'h22, 32'h0, 0, 0, 5'd0);
        chk("c7_pend", cfg_rdata, 32'h0);
        step(8'h00, 1, 0, 6'h03, 32'd1, 0, 0, 5'd0);
        step(8'h00, 1, 0, 6'h20, 32'h08, 0, 0, 5'd0);
        step(8'h04, 0, 0, 6'h00, 32'h0, 0, 0, 5'd0);
        step(8'h04, 0, 1, 6'h22, 32'h0, 0, 0, 5'd0);
        chk("c11_pend", cfg_rdata, 32'h08);
        chk("c11_meip", 32'(meip), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/plic_lite.md
Name: plic_lite

Overview:
- Minimal platform-level interrupt controller that sits directly upstream of the machine trap handler.
- Collects level-sensitive external interrupt lines, gates and prioritises them, and drives the machine external interrupt pending bit (mip[11], MEIP) into the CSR file.
- Software takes the winning source ID with a claim/complete handshake.
- Configuration goes through a simple word-addressed register port.

Parameters:
- NSRC, 8, number of interrupt sources; IDs are 1..NSRC, ID 0 is reserved for "none" (NSRC max 31).
- PRIO_W, 3, width of each priority field and of the threshold.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- resetn  input  1  reset, synchronous and active-low.
- irq_src  input  NSRC  level interrupt lines; bit i-1 is source ID i.
- cfg_we  input  1  register write strobe.
- cfg_re  input  1  register read strobe.
- cfg_addr  input  6  word address.
- cfg_wdata  input  32  write data.
- cfg_rdata  output  32  read data, valid the cycle after cfg_re.
- claim_req  input  1  one-cycle claim pulse.
- claim_id  output  5  claimed ID, valid the cycle after claim_req; 0 means nothing to claim.
- complete_req  input  1  one-cycle completion pulse.
- complete_id  input  5  ID being completed.
- meip  output  1  external interrupt pending, to CSR mip[11].

Behaviour:
- Register map (word addresses):
  - 0x01..NSRC: priority[ID], low PRIO_W bits, RW.
  - 0x20: enable, bit i = ID i, bit 0 reads 0, RW.
  - 0x21: threshold, RW.
  - 0x22: pending, RO, bit i = ID i.
  - Other addresses: read 0, writes ignored.
- Reset: every priority, enable, threshold, pending and inflight bit = 0; meip=0, claim_id=0, cfg_rdata=0.
- Gateway per ID:
  - pending[i] is set on a cycle where irq_src high and pending[i]=0 and inflight[i]=0.
  - Claim of i clears pending[i] and sets inflight[i].
  - Complete of i clears inflight[i]. If the line is still high, pending re-sets the following cycle.
- Eligibility: ID i is eligible iff pending & enable & priority[i] > threshold. Priority 0 is therefore never eligible.
- Arbitration is combinational over eligible IDs: highest priority wins; ties go to the lowest ID. best_id = 0 if none is eligible.
- meip is registered: meip <= (best_id != 0). A pending change is visible on meip exactly 1 cycle later.
- Claim: on claim_req, claim_id <= best_id at that edge and the claim side effects apply on the same edge. claim_id holds its value until the next claim_req. Claim with best_id=0 returns 0 and changes no state.
- Complete: complete_id of 0 or > NSRC is ignored. Completing an ID that is not inflight has no effect.
- Simultaneous claim_req and complete_req:
  - Both apply on the same edge.
  - If complete_id equals the ID being claimed (not possible when the ID is inflight), claim wins.
- Simultaneous irq set and claim of the same ID: the claim wins; pending ends 0 and inflight ends 1.
- Config write and arbitration:
  - A write takes effect on the edge; arbitration uses post-write values from the next cycle.
  - A write to the pending address is ignored.
  - Read returns the pre-write value if read and write hit the same address in the same cycle.
- Only one outstanding claim per ID. Multiple IDs may be inflight at once (nesting).
- Reset mid-operation clears all state, including inflight, within one edge. meip=0 the cycle after resetn is sampled low.

Test Plan:
- Reset then prio[3]=2, enable=0x08, threshold=0, pulse irq_src[2] high -> pending=0x08, meip=1 one cycle after pending sets; claim -> claim_id=3, meip=0 next cycle, pending=0.
- prio[2]=5, prio[5]=5, prio[6]=7, all enabled, lines 2/5/6 high -> claims return 6, then 2, then 5, then 0.
- threshold=4 with prio[1]=4, line 1 high, enabled -> meip stays 0; write threshold=3 -> meip=1 next cycle.
- Claim ID 3 with line held high, no complete -> pending[3] stays 0, meip=0; complete_id=3 -> pending[3]=1 next cycle, meip=1 the cycle after.
- Same cycle: claim_req and complete_req with complete_id=3 (inflight), line 4 eligible -> claim_id=4, inflight=0x10, ID 3 re-pends if its line is high; complete_id=0 or 9 -> no state change.
- Assert resetn low with two IDs inflight and meip=1 -> next cycle all registers 0, meip=0, claim_id=0.
